// File: rtl/sync_fifo_pro.sv
// Synchronous FIFO with arbitrary depth, occupancy count, almost-full/empty flags,
// flush and read-valid strobe. Define SYNC_FIFO_ERR_FLAGS_EN to add sticky o_ovf/o_udf.
module sync_fifo_pro #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter int unsigned AFULL_THRESH  = FIFO_DEPTH - 2,
  parameter int unsigned AEMPTY_THRESH = 2,
  localparam int unsigned CNT_W        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rts_n,
  input  logic                  i_clr,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_empty,
  output logic                  o_full,
  output logic                  o_afull,
  output logic                  o_aempty,
  output logic [CNT_W-1:0]      o_count
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  ,
  output logic                  o_ovf,
  output logic                  o_udf
`endif
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr_nxt;
  logic [PTR_W-1:0]      rd_ptr_nxt;
  logic [CNT_W-1:0]      count_nxt;
  logic                  push_ok;
  logic                  pop_ok;

  // Acceptance, pointer wrap and next occupancy (reset/flush collapse to empty)
  always_comb begin
    pop_ok     = i_pop & ~o_empty;
    push_ok    = i_push & (~o_full | pop_ok);
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    count_nxt  = o_count;
    if (!i_rts_n || i_clr) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      count_nxt  = '0;
    end else begin
      if (push_ok) begin
        wr_ptr_nxt = (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_nxt = (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      if (push_ok && !pop_ok) begin
        count_nxt = o_count + CNT_W'(1);
      end else if (pop_ok && !push_ok) begin
        count_nxt = o_count - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    wr_ptr   <= wr_ptr_nxt;
    rd_ptr   <= rd_ptr_nxt;
    o_count  <= count_nxt;
    o_empty  <= (count_nxt == '0);
    o_full   <= (count_nxt == CNT_W'(FIFO_DEPTH));
    o_afull  <= (count_nxt >= CNT_W'(AFULL_THRESH));
    o_aempty <= (count_nxt <= CNT_W'(AEMPTY_THRESH));
  end

  // Storage is not reset; writes are blocked during reset and flush
  always_ff @(posedge i_clk) begin
    if (i_rts_n && !i_clr && push_ok) begin
      mem[wr_ptr] <= i_data;
    end
  end

  // Registered read port: data appears with o_valid the cycle after an accepted pop
  always_ff @(posedge i_clk) begin
    if (!i_rts_n) begin
      o_data  <= '0;
      o_valid <= 1'b0;
    end else if (i_clr) begin
      o_valid <= 1'b0;
    end else begin
      o_valid <= pop_ok;
      if (pop_ok) begin
        o_data <= mem[rd_ptr];
      end
    end
  end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  // Sticky overflow/underflow; flush wins over a coincident error
  always_ff @(posedge i_clk) begin
    if (!i_rts_n || i_clr) begin
      o_ovf <= 1'b0;
      o_udf <= 1'b0;
    end else begin
      if (i_push && !push_ok) begin
        o_ovf <= 1'b1;
      end
      if (i_pop && !pop_ok) begin
        o_udf <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_pro.sv
// Randomised self-checking bench for sync_fifo_pro: a depth-16 and a depth-5 instance
// share stimulus and are each compared against a queue-based reference model.
module tb_sync_fifo_pro;

  logic       clk = 1'b0;
  logic       rts_n;
  logic       clr;
  logic       push;
  logic       pop;
  logic [7:0] din;

  logic [7:0] data0, data1;
  logic       valid0, valid1, empty0, empty1, full0, full1;
  logic       afull0, afull1, aempty0, aempty1;
  logic [4:0] count0;
  logic [2:0] count1;
  logic       ovf0, ovf1, udf0, udf1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sync_fifo_pro #(.DATA_WIDTH(8), .FIFO_DEPTH(16)) u_dut16 (
    .i_clk(clk), .i_rts_n(rts_n), .i_clr(clr), .i_push(push), .i_data(din), .i_pop(pop),
    .o_data(data0), .o_valid(valid0), .o_empty(empty0), .o_full(full0),
    .o_afull(afull0), .o_aempty(aempty0), .o_count(count0)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    , .o_ovf(ovf0), .o_udf(udf0)
`endif
  );

  sync_fifo_pro #(.DATA_WIDTH(8), .FIFO_DEPTH(5), .AFULL_THRESH(4), .AEMPTY_THRESH(1)) u_dut5 (
    .i_clk(clk), .i_rts_n(rts_n), .i_clr(clr), .i_push(push), .i_data(din), .i_pop(pop),
    .o_data(data1), .o_valid(valid1), .o_empty(empty1), .o_full(full1),
    .o_afull(afull1), .o_aempty(aempty1), .o_count(count1)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    , .o_ovf(ovf1), .o_udf(udf1)
`endif
  );

`ifndef SYNC_FIFO_ERR_FLAGS_EN
  assign ovf0 = 1'b0;
  assign ovf1 = 1'b0;
  assign udf0 = 1'b0;
  assign udf1 = 1'b0;
`endif

  // Reference model: one queue per instance plus expected read-port and error state
  logic [7:0] q [2][$];
  int         depth_m  [2] = '{16, 5};
  int         afull_m  [2] = '{14, 4};
  int         aempty_m [2] = '{2, 1};
  logic [7:0] exp_data [2];
  logic       exp_valid[2];
  logic       exp_ovf  [2];
  logic       exp_udf  [2];
  int         max_cnt5 = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (!rts_n) begin
        q[k].delete();
        exp_data[k]  = 8'h00;
        exp_valid[k] = 1'b0;
        exp_ovf[k]   = 1'b0;
        exp_udf[k]   = 1'b0;
      end else if (clr) begin
        q[k].delete();
        exp_valid[k] = 1'b0;
        exp_ovf[k]   = 1'b0;
        exp_udf[k]   = 1'b0;
      end else begin
        bit pop_ok, push_ok;
        pop_ok  = pop && (q[k].size() > 0);
        push_ok = push && ((q[k].size() < depth_m[k]) || pop_ok);
        if (push && !push_ok) exp_ovf[k] = 1'b1;
        if (pop && !pop_ok) exp_udf[k] = 1'b1;
        exp_valid[k] = pop_ok;
        if (pop_ok) exp_data[k] = q[k].pop_front();
        if (push_ok) q[k].push_back(din);
      end
    end
  endtask

  task automatic check_inst(input int k, input logic [7:0] d, input logic v, input int cnt,
                            input logic e, input logic f, input logic af, input logic ae,
                            input logic ov, input logic ud);
    int sz;
    sz = q[k].size();
    check($sformatf("i%0d_count", k), 32'(cnt), 32'(sz));
    check($sformatf("i%0d_valid", k), 32'(v), 32'(exp_valid[k]));
    check($sformatf("i%0d_data", k), 32'(d), 32'(exp_data[k]));
    check($sformatf("i%0d_empty", k), 32'(e), 32'(sz == 0));
    check($sformatf("i%0d_full", k), 32'(f), 32'(sz == depth_m[k]));
    check($sformatf("i%0d_afull", k), 32'(af), 32'(sz >= afull_m[k]));
    check($sformatf("i%0d_aempty", k), 32'(ae), 32'(sz <= aempty_m[k]));
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    check($sformatf("i%0d_ovf", k), 32'(ov), 32'(exp_ovf[k]));
    check($sformatf("i%0d_udf", k), 32'(ud), 32'(exp_udf[k]));
`else
    if (ov !== 1'b0 || ud !== 1'b0) check($sformatf("i%0d_errtie", k), 32'({ov, ud}), 32'(0));
`endif
  endtask

  // One clock: apply inputs, advance the model, check both instances just after the edge
  task automatic step(input logic p, input logic [7:0] d, input logic r,
                      input logic c = 1'b0, input logic rn = 1'b1);
    push  = p;
    din   = d;
    pop   = r;
    clr   = c;
    rts_n = rn;
    model_step();
    @(posedge clk);
    #1;
    check_inst(0, data0, valid0, int'(count0), empty0, full0, afull0, aempty0, ovf0, udf0);
    check_inst(1, data1, valid1, int'(count1), empty1, full1, afull1, aempty1, ovf1, udf1);
    if (int'(count1) > max_cnt5) max_cnt5 = int'(count1);
  endtask

  initial begin
    logic [7:0] seq;
    int         push_pct;
    int         pop_pct;
    push = 1'b0; pop = 1'b0; clr = 1'b0; din = 8'h00; rts_n = 1'b0;

    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);

    // Fill with 0x01..0x10, then an overflowing push
    for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0);
    check("full_after_fill", 32'(full0), 32'(1));
    step(1'b1, 8'hFF, 1'b0);

    // Drain, then one extra pop on empty
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    check("empty_after_drain", 32'(empty0), 32'(1));

    // Simultaneous push/pop at full and at empty
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h20 + 8'(i)), 1'b0);
    step(1'b1, 8'hAA, 1'b1);
    check("full_pushpop_data", 32'(data0), 32'(8'h20));
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h55, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    check("empty_pushpop_data", 32'(data0), 32'(8'h55));

    // Randomised phases with an incrementing data stream and rare flushes
    seq = 8'h00;
    for (int ph = 0; ph < 12; ph++) begin
      push_pct = (ph % 3 == 0) ? 85 : (ph % 3 == 1) ? 20 : 50;
      pop_pct  = (ph % 3 == 0) ? 20 : (ph % 3 == 1) ? 85 : 50;
      for (int i = 0; i < 30; i++) begin
        logic p, r, c;
        p = ($urandom_range(99) < push_pct);
        r = ($urandom_range(99) < pop_pct);
        c = ($urandom_range(63) == 0);
        step(p, seq, r, c);
        if (p) seq = seq + 8'd1;
      end
    end
    check("depth5_count_bound", 32'(max_cnt5 <= 5), 32'(1));

    // Flush with coincident push and pop
    step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h40 + 8'(i)), 1'b0);
    step(1'b1, 8'h99, 1'b1, 1'b1);
    check("flush_count", 32'(count0), 32'(0));
    step(1'b1, 8'h3C, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    check("flush_then_3c", 32'(data0), 32'(8'h3C));

    // Reset mid-stream, then glitches on reset between edges
    for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h60 + 8'(i)), 1'b0);
    step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h70 + 8'(i)), 1'b0);
    rts_n = 1'b0; #2; rts_n = 1'b1;
    step(1'b0, 8'h00, 1'b1);
    rts_n = 1'b0; #3; rts_n = 1'b1;
    step(1'b0, 8'h00, 1'b1);
    check("glitch_no_reset", 32'(data0), 32'(8'h71));
    for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
